// File: rtl/ram_sync_dp_if.sv
// Bus bundle for ram_sync_dp: the master drives requests, the RAM drives status and read data.
// Handshake: wr_en/rd_en are taken at a rising edge only while busy=0 (otherwise dropped with err);
// rd_valid marks the one cycle in which data_out holds a read result; err is a one-cycle pulse.
interface ram_sync_dp_if #(
  parameter int ADDR_SIZE = 10,
  parameter int WORD_SIZE = 32
);
  logic                   clr_req;
  logic                   busy;
  logic                   wr_en;
  logic [ADDR_SIZE-1:0]   wr_addr;
  logic [WORD_SIZE/8-1:0] be;
  logic [WORD_SIZE-1:0]   data_in;
  logic                   rd_en;
  logic [ADDR_SIZE-1:0]   rd_addr;
  logic [WORD_SIZE-1:0]   data_out;
  logic                   rd_valid;
  logic                   err;
  logic                   state;

  modport master (
    output clr_req, wr_en, wr_addr, be, data_in, rd_en, rd_addr,
    input  busy, data_out, rd_valid, err, state
  );

  modport slave (
    input  clr_req, wr_en, wr_addr, be, data_in, rd_en, rd_addr,
    output busy, data_out, rd_valid, err, state
  );
endinterface

// File: rtl/ram_sync_dp.sv
// Synchronous simple-dual-port RAM with byte-enable writes, selectable read latency and
// collision mode, and a clear engine that zeroes the array after reset or on request.
module ram_sync_dp #(
  parameter int ADDR_SIZE   = 10,
  parameter int WORD_SIZE   = 32,
  parameter int MEMORY_SIZE = 1024,
  parameter int RD_MODE     = 0,
  parameter int OUT_REG     = 0
) (
  input logic          clk,
  input logic          rst_n,
  ram_sync_dp_if.slave bus
);
  localparam int NBYTES = WORD_SIZE / 8;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR  = ADDR_SIZE'(MEMORY_SIZE - 1);
  localparam logic [ADDR_SIZE:0]   ADDR_LIMIT = (ADDR_SIZE + 1)'(MEMORY_SIZE);

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] clr_ptr_q, clr_ptr_d;
  logic [WORD_SIZE-1:0] mem [MEMORY_SIZE];

  logic                 idle;
  logic                 wr_in, rd_in;
  logic                 wr_ok, rd_hit, rd_ok;
  logic                 req_err;
  logic [WORD_SIZE-1:0] rd_word;
  logic [WORD_SIZE-1:0] data1;
  logic                 valid1;
  logic                 err_q;

  assign idle   = (state_q == IDLE);
  assign wr_in  = ({1'b0, bus.wr_addr} < ADDR_LIMIT);
  assign rd_in  = ({1'b0, bus.rd_addr} < ADDR_LIMIT);
  assign wr_ok  = idle & bus.wr_en & wr_in;
  assign rd_hit = idle & bus.rd_en;
  assign rd_ok  = rd_hit & rd_in;
  // While clearing every request is dropped; when idle only out-of-range ones are.
  assign req_err = idle ? ((bus.wr_en & ~wr_in) | (bus.rd_en & ~rd_in))
                        : (bus.wr_en | bus.rd_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      CLEAR: begin
        if (clr_ptr_q == LAST_ADDR) begin
          state_d   = IDLE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      IDLE: begin
        if (bus.clr_req) state_d = CLEAR;
      end
      default: state_d = CLEAR;
    endcase
  end

  // The array has no reset; it is zeroed by the clear engine instead.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clr_ptr_q] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (bus.be[i]) mem[bus.wr_addr][8*i +: 8] <= bus.data_in[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      rd_word = mem[bus.rd_addr];
      if (RD_MODE != 0 && wr_ok && bus.wr_addr == bus.rd_addr) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (bus.be[i]) rd_word[8*i +: 8] = bus.data_in[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data1  <= '0;
      valid1 <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q  <= req_err;
      valid1 <= rd_hit;
      if (rd_hit) data1 <= rd_word;
    end
  end

  // Second stage only advances on a completed read so data_out holds between reads.
  if (OUT_REG != 0) begin : g_out_reg
    logic [WORD_SIZE-1:0] data2;
    logic                 valid2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data2  <= '0;
        valid2 <= 1'b0;
      end else begin
        valid2 <= valid1;
        if (valid1) data2 <= data1;
      end
    end

    assign bus.data_out = data2;
    assign bus.rd_valid = valid2;
  end else begin : g_no_out_reg
    assign bus.data_out = data1;
    assign bus.rd_valid = valid1;
  end

  assign bus.busy  = ~idle;
  assign bus.err   = err_q;
  assign bus.state = state_q;
endmodule

// File: tb/tb_ram_sync_dp.sv
// Directed bench: instance a is read-first/latency 1/1024 words, instance b is
// write-first/latency 2/1000 words; both receive the same request stream.
module tb_ram_sync_dp;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic        clr_req, wr_en, rd_en;
  logic [9:0]  wr_addr, rd_addr;
  logic [3:0]  be;
  logic [31:0] data_in;
  int          cyc;

  always #5 clk = ~clk;

  ram_sync_dp_if #(.ADDR_SIZE(10), .WORD_SIZE(32)) bus_a ();
  ram_sync_dp_if #(.ADDR_SIZE(10), .WORD_SIZE(32)) bus_b ();

  assign bus_a.clr_req = clr_req;
  assign bus_a.wr_en   = wr_en;
  assign bus_a.wr_addr = wr_addr;
  assign bus_a.be      = be;
  assign bus_a.data_in = data_in;
  assign bus_a.rd_en   = rd_en;
  assign bus_a.rd_addr = rd_addr;
  assign bus_b.clr_req = clr_req;
  assign bus_b.wr_en   = wr_en;
  assign bus_b.wr_addr = wr_addr;
  assign bus_b.be      = be;
  assign bus_b.data_in = data_in;
  assign bus_b.rd_en   = rd_en;
  assign bus_b.rd_addr = rd_addr;

  ram_sync_dp #(.ADDR_SIZE(10), .WORD_SIZE(32), .MEMORY_SIZE(1024), .RD_MODE(0), .OUT_REG(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  ram_sync_dp #(.ADDR_SIZE(10), .WORD_SIZE(32), .MEMORY_SIZE(1000), .RD_MODE(1), .OUT_REG(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] b,
                    input logic ea, input logic eb);
    wr_en = 1'b1; wr_addr = a; data_in = d; be = b;
    tick();
    wr_en = 1'b0;
    chk($sformatf("wr%0d err_a", a), 32'(bus_a.err), 32'(ea));
    chk($sformatf("wr%0d err_b", a), 32'(bus_b.err), 32'(eb));
  endtask

  task automatic rd2(input logic [9:0] a, input logic [31:0] ea, input logic [31:0] eb,
                     input logic eerr_b);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk($sformatf("rd%0d valid_a", a), 32'(bus_a.rd_valid), 32'd1);
    chk($sformatf("rd%0d data_a", a), bus_a.data_out, ea);
    chk($sformatf("rd%0d err_a", a), 32'(bus_a.err), 32'd0);
    chk($sformatf("rd%0d valid_b_early", a), 32'(bus_b.rd_valid), 32'd0);
    chk($sformatf("rd%0d err_b", a), 32'(bus_b.err), 32'(eerr_b));
    tick();
    chk($sformatf("rd%0d valid_a_after", a), 32'(bus_a.rd_valid), 32'd0);
    chk($sformatf("rd%0d data_a_hold", a), bus_a.data_out, ea);
    chk($sformatf("rd%0d valid_b", a), 32'(bus_b.rd_valid), 32'd1);
    chk($sformatf("rd%0d data_b", a), bus_b.data_out, eb);
  endtask

  // Counts edges from `start` until a leaves busy, noting where b leaves busy.
  task automatic wait_clear(input int start, input string tag);
    int n  = start;
    int nb = -1;
    while (bus_a.busy && n < 3000) begin
      tick();
      n++;
      if (!bus_b.busy && nb < 0) nb = n;
    end
    chk({tag, " busy_len_a"}, 32'(n), 32'd1024);
    chk({tag, " busy_len_b"}, 32'(nb), 32'd1000);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, " busy_a"}, 32'(bus_a.busy), 32'd1);
    chk({tag, " busy_b"}, 32'(bus_b.busy), 32'd1);
    chk({tag, " data_a"}, bus_a.data_out, 32'd0);
    chk({tag, " data_b"}, bus_b.data_out, 32'd0);
    chk({tag, " valid_a"}, 32'(bus_a.rd_valid), 32'd0);
    chk({tag, " valid_b"}, 32'(bus_b.rd_valid), 32'd0);
    chk({tag, " err_a"}, 32'(bus_a.err), 32'd0);
    chk({tag, " err_b"}, 32'(bus_b.err), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; be = '0; data_in = '0;

    // Power-on reset and automatic clear
    #2 rst_n = 1'b0;
    #1 reset_vals("por");
    repeat (3) tick();
    rst_n = 1'b1;
    wait_clear(0, "por");

    rd2(10'd0,    32'h0, 32'h0, 1'b0);
    rd2(10'd513,  32'h0, 32'h0, 1'b0);
    rd2(10'd1023, 32'h0, 32'h0, 1'b1);

    // Byte-enable merge
    wr(10'd5, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0);
    wr(10'd5, 32'h11223344, 4'b0101, 1'b0, 1'b0);
    rd2(10'd5, 32'hDE22BE44, 32'hDE22BE44, 1'b0);

    // Same-address collision
    wr(10'd7, 32'hAAAAAAAA, 4'b1111, 1'b0, 1'b0);
    wr_en = 1'b1; wr_addr = 10'd7; data_in = 32'h55555555; be = 4'b0011;
    rd_en = 1'b1; rd_addr = 10'd7;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("coll data_a", bus_a.data_out, 32'hAAAAAAAA);
    chk("coll valid_b_early", 32'(bus_b.rd_valid), 32'd0);
    tick();
    chk("coll valid_b", 32'(bus_b.rd_valid), 32'd1);
    chk("coll data_b", bus_b.data_out, 32'hAAAA5555);
    rd2(10'd7, 32'hAAAA5555, 32'hAAAA5555, 1'b0);

    // Back-to-back reads
    rd_en = 1'b1; rd_addr = 10'd5;
    tick();
    rd_addr = 10'd7;
    chk("stream0 valid_a", 32'(bus_a.rd_valid), 32'd1);
    chk("stream0 data_a", bus_a.data_out, 32'hDE22BE44);
    chk("stream0 valid_b", 32'(bus_b.rd_valid), 32'd0);
    tick();
    rd_en = 1'b0;
    chk("stream1 valid_a", 32'(bus_a.rd_valid), 32'd1);
    chk("stream1 data_a", bus_a.data_out, 32'hAAAA5555);
    chk("stream1 valid_b", 32'(bus_b.rd_valid), 32'd1);
    chk("stream1 data_b", bus_b.data_out, 32'hDE22BE44);
    tick();
    chk("stream2 valid_a", 32'(bus_a.rd_valid), 32'd0);
    chk("stream2 valid_b", 32'(bus_b.rd_valid), 32'd1);
    chk("stream2 data_b", bus_b.data_out, 32'hAAAA5555);

    // Out-of-range on b (1000 words), in range on a
    wr(10'd1000, 32'h12345678, 4'b1111, 1'b0, 1'b1);
    rd2(10'd1000, 32'h12345678, 32'h0, 1'b1);
    rd2(10'd0, 32'h0, 32'h0, 1'b0);
    wr_en = 1'b1; wr_addr = 10'd1001; data_in = 32'hFFFF0000; be = 4'b1111;
    rd_en = 1'b1; rd_addr = 10'd1002;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("oor_both err_b", 32'(bus_b.err), 32'd1);
    chk("oor_both err_a", 32'(bus_a.err), 32'd0);
    chk("oor_both data_a", bus_a.data_out, 32'h0);
    tick();
    chk("oor_both err_b_single", 32'(bus_b.err), 32'd0);
    chk("oor_both valid_b", 32'(bus_b.rd_valid), 32'd1);
    chk("oor_both data_b", bus_b.data_out, 32'h0);

    // Zero byte enables: no change, no error
    wr(10'd9, 32'hFFFFFFFF, 4'b0000, 1'b0, 1'b0);
    rd2(10'd9, 32'h0, 32'h0, 1'b0);

    // Clear request with a read in flight, then dropped requests while busy
    clr_req = 1'b1; rd_en = 1'b1; rd_addr = 10'd5;
    tick();
    clr_req = 1'b0; rd_en = 1'b0; cyc = 0;
    chk("clr busy_a", 32'(bus_a.busy), 32'd1);
    chk("clr busy_b", 32'(bus_b.busy), 32'd1);
    chk("clr inflight valid_a", 32'(bus_a.rd_valid), 32'd1);
    chk("clr inflight data_a", bus_a.data_out, 32'hDE22BE44);
    tick(); cyc++;
    chk("clr inflight valid_b", 32'(bus_b.rd_valid), 32'd1);
    chk("clr inflight data_b", bus_b.data_out, 32'hDE22BE44);
    clr_req = 1'b1;
    tick(); cyc++;
    clr_req = 1'b0;
    while (cyc < 9) begin
      tick(); cyc++;
    end
    rd_en = 1'b1; rd_addr = 10'd7;
    tick(); cyc++;
    rd_en = 1'b0;
    chk("busy_rd err_a", 32'(bus_a.err), 32'd1);
    chk("busy_rd err_b", 32'(bus_b.err), 32'd1);
    chk("busy_rd valid_a", 32'(bus_a.rd_valid), 32'd0);
    tick(); cyc++;
    chk("busy_rd valid_b", 32'(bus_b.rd_valid), 32'd0);
    chk("busy_rd err_a_end", 32'(bus_a.err), 32'd0);
    wr_en = 1'b1; wr_addr = 10'd2; data_in = 32'h12345678; be = 4'b1111;
    tick(); cyc++;
    wr_en = 1'b0;
    chk("busy_wr err_a", 32'(bus_a.err), 32'd1);
    chk("busy_wr err_b", 32'(bus_b.err), 32'd1);
    wait_clear(cyc, "clr_req");

    rd2(10'd2, 32'h0, 32'h0, 1'b0);
    rd2(10'd5, 32'h0, 32'h0, 1'b0);
    rd2(10'd7, 32'h0, 32'h0, 1'b0);

    // Full sweep, one read per cycle
    for (int i = 0; i < 1024; i++) begin
      rd_en = 1'b1; rd_addr = 10'(i);
      tick();
      chk("sweep valid_a", 32'(bus_a.rd_valid), 32'd1);
      chk("sweep data_a", bus_a.data_out, 32'h0);
      if (i > 0) begin
        chk("sweep valid_b", 32'(bus_b.rd_valid), 32'd1);
        chk("sweep data_b", bus_b.data_out, 32'h0);
      end
    end
    rd_en = 1'b0;
    tick();
    chk("sweep last valid_b", 32'(bus_b.rd_valid), 32'd1);

    // Reset in the middle of a clear restarts it from address 0
    wr(10'd5, 32'hCAFEF00D, 4'b1111, 1'b0, 1'b0);
    rd2(10'd5, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (300) tick();
    chk("midclr busy_a", 32'(bus_a.busy), 32'd1);
    rst_n = 1'b0;
    #1 reset_vals("midclr_rst");
    repeat (3) tick();
    reset_vals("midclr_hold");
    rst_n = 1'b1;
    wait_clear(0, "midclr");
    rd2(10'd5, 32'h0, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
